// File: rtl/rect_plot_scheduler.sv
// rect_plot_scheduler: round-robin owner of the VGA plot port.
// Latches one requester's rectangle and rasters it one pixel per clock.
module rect_plot_scheduler #(
  parameter int NREQ  = 3,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] rect_x,
  input  logic [NREQ*7-1:0] rect_y,
  input  logic [NREQ*8-1:0] rect_w,
  input  logic [NREQ*7-1:0] rect_h,
  input  logic [NREQ*3-1:0] rect_color,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [7:0]        VGA_X,
  output logic [6:0]        VGA_Y,
  output logic [2:0]        VGA_COLOR,
  output logic              plot
);

  localparam int IW = $clog2(NREQ);
  localparam logic [8:0] XLIM = 9'(SCR_W);
  localparam logic [7:0] YLIM = 8'(SCR_H);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]   last;
  logic [IW-1:0]   sel;
  logic            found;
  logic [NREQ-1:0] sel_oh;

  logic [7:0] sx, sw;
  logic [6:0] sy, sh;
  logic [2:0] sc;
  logic       empty_sel;

  logic [7:0] x0, w0, cx;
  logic [6:0] y0, h0, cy;
  logic [2:0] c0;

  logic [8:0] px;
  logic [7:0] py;
  logic       last_px;

  // Round-robin search: first set req after the last winner.
  always_comb begin
    int j;
    found = 1'b0;
    sel   = last;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last) + k) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  // Pick out the winning requester's rectangle fields.
  always_comb begin
    sx = '0;
    sy = '0;
    sw = '0;
    sh = '0;
    sc = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IW'(i)) begin
        sx = rect_x[i*8 +: 8];
        sy = rect_y[i*7 +: 7];
        sw = rect_w[i*8 +: 8];
        sh = rect_h[i*7 +: 7];
        sc = rect_color[i*3 +: 3];
      end
    end
  end

  assign sel_oh    = {{(NREQ-1){1'b0}}, 1'b1} << sel;
  assign empty_sel = (sw == 8'd0) || (sh == 7'd0);

  // Widened coordinates so off-screen pixels never wrap back on.
  assign px      = {1'b0, x0} + {1'b0, cx};
  assign py      = {1'b0, y0} + {1'b0, cy};
  assign last_px = (cx == w0 - 8'd1) && (cy == h0 - 7'd1);

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (found) state_nx = empty_sel ? DONE : DRAW;
      end
      DRAW: begin
        if (last_px) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs, latched rectangle and raster counters.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      last      <= IW'(NREQ - 1);
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
      plot      <= 1'b0;
      x0        <= '0;
      y0        <= '0;
      w0        <= '0;
      h0        <= '0;
      c0        <= '0;
      cx        <= '0;
      cy        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          plot <= 1'b0;
          done <= '0;
          if (found) begin
            x0    <= sx;
            y0    <= sy;
            w0    <= sw;
            h0    <= sh;
            c0    <= sc;
            cx    <= '0;
            cy    <= '0;
            last  <= sel;
            grant <= sel_oh;
            busy  <= 1'b1;
            if (empty_sel) done <= sel_oh;
          end
        end
        DRAW: begin
          VGA_X     <= px[7:0];
          VGA_Y     <= py[6:0];
          VGA_COLOR <= c0;
          plot      <= (px < XLIM) && (py < YLIM);
          if (cx == w0 - 8'd1) begin
            cx <= '0;
            cy <= cy + 7'd1;
          end else begin
            cx <= cx + 8'd1;
          end
          if (last_px) done <= grant;
        end
        DONE: begin
          plot  <= 1'b0;
          done  <= '0;
          grant <= '0;
          busy  <= 1'b0;
        end
        default: begin
          plot  <= 1'b0;
          done  <= '0;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_plot_scheduler.sv
// tb_rect_plot_scheduler: scoreboard bench for rect_plot_scheduler.
// Stimulus queues expected grants/pixels/dones; a monitor pops them.
module tb_rect_plot_scheduler;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] rect_x;
  logic [20:0] rect_y;
  logic [23:0] rect_w;
  logic [20:0] rect_h;
  logic [8:0]  rect_color;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_color;
  logic        plot;

  int checks = 0;
  int errors = 0;

  logic [17:0] pix_q[$];
  logic [2:0]  grant_q[$];
  logic [3:0]  done_q[$];

  rect_plot_scheduler #(.NREQ(3), .SCR_W(160), .SCR_H(120)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .req       (req),
    .rect_x    (rect_x),
    .rect_y    (rect_y),
    .rect_w    (rect_w),
    .rect_h    (rect_h),
    .rect_color(rect_color),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .VGA_X     (vga_x),
    .VGA_Y     (vga_y),
    .VGA_COLOR (vga_color),
    .plot      (plot)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_rect(input int i, input int x, input int y,
                          input int w, input int h, input int c);
    rect_x[i*8 +: 8]     = 8'(x);
    rect_y[i*7 +: 7]     = 7'(y);
    rect_w[i*8 +: 8]     = 8'(w);
    rect_h[i*7 +: 7]     = 7'(h);
    rect_color[i*3 +: 3] = 3'(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int m);
    m = 0;
    do begin
      tick();
      m++;
    end while (grant == 3'b000 && m < 20);
    if (grant == 3'b000) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout actual none required grant");
    end
  endtask

  task automatic wait_idle(input string name, input int occ_exp);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(name, n, occ_exp);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"},  done,  0);
    chk({tag, "_busy"},  busy,  0);
    chk({tag, "_plot"},  plot,  0);
    chk({tag, "_x"},     vga_x, 0);
    chk({tag, "_y"},     vga_y, 0);
    chk({tag, "_col"},   vga_color, 0);
  endtask

  task automatic monitor();
    logic [2:0] pg;
    pg = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pg = '0;
      end else begin
        if (grant != 3'b000 && grant != pg) begin
          if (grant_q.size() == 0) chk("grant_unexpected", grant, 0);
          else chk("grant_order", grant, grant_q.pop_front());
        end
        pg = grant;
        if (plot) begin
          if (pix_q.size() == 0)
            chk("plot_unexpected", {vga_x, vga_y, vga_color}, 0);
          else
            chk("pixel", {vga_x, vga_y, vga_color}, pix_q.pop_front());
        end
        if (done != 3'b000) begin
          if (done_q.size() == 0) chk("done_unexpected", {plot, done}, 0);
          else chk("done_plot", {plot, done}, done_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    int m;
    reset      = 1'b1;
    req        = '0;
    rect_x     = '0;
    rect_y     = '0;
    rect_w     = '0;
    rect_h     = '0;
    rect_color = '0;
    fork
      monitor();
    join_none

    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // 1: single 2x2 draw
    set_rect(0, 10, 20, 2, 2, 4);
    grant_q.push_back(3'b001);
    pix_q.push_back({8'd10, 7'd20, 3'd4});
    pix_q.push_back({8'd11, 7'd20, 3'd4});
    pix_q.push_back({8'd10, 7'd21, 3'd4});
    pix_q.push_back({8'd11, 7'd21, 3'd4});
    done_q.push_back({1'b1, 3'b001});
    req[0] = 1'b1;
    wait_grant(m);
    chk("t1_grant_lat", m, 1);
    req[0] = 1'b0;
    wait_idle("t1_occupancy", 5);
    tick();

    // 2: clipping at bottom-right corner
    set_rect(1, 158, 119, 4, 2, 2);
    grant_q.push_back(3'b010);
    pix_q.push_back({8'd158, 7'd119, 3'd2});
    pix_q.push_back({8'd159, 7'd119, 3'd2});
    done_q.push_back({1'b0, 3'b010});
    req[1] = 1'b1;
    wait_grant(m);
    chk("t2_grant_lat", m, 1);
    req[1] = 1'b0;
    wait_idle("t2_occupancy", 9);
    tick();

    // 3: empty rectangle
    set_rect(2, 50, 50, 0, 5, 7);
    grant_q.push_back(3'b100);
    done_q.push_back({1'b0, 3'b100});
    req[2] = 1'b1;
    wait_grant(m);
    chk("t3_grant_lat", m, 1);
    chk("t3_done_with_grant", done, 3'b100);
    req[2] = 1'b0;
    wait_idle("t3_occupancy", 1);
    tick();

    // 4: round robin, all requesters held with 1x1 rects
    set_rect(0, 0, 5, 1, 1, 1);
    set_rect(1, 10, 5, 1, 1, 2);
    set_rect(2, 20, 5, 1, 1, 3);
    for (int r = 0; r < 2; r++) begin
      grant_q.push_back(3'b001);
      grant_q.push_back(3'b010);
      grant_q.push_back(3'b100);
      pix_q.push_back({8'd0, 7'd5, 3'd1});
      pix_q.push_back({8'd10, 7'd5, 3'd2});
      pix_q.push_back({8'd20, 7'd5, 3'd3});
      done_q.push_back({1'b1, 3'b001});
      done_q.push_back({1'b1, 3'b010});
      done_q.push_back({1'b1, 3'b100});
    end
    req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      wait_grant(m);
      if (g > 0) chk("t4_idle_gap", m, 1);
      if (g == 5) req = 3'b000;
      wait_idle("t4_occupancy", 2);
    end
    tick();

    // 5: reset during 3rd pixel of a 4x4 draw
    set_rect(1, 30, 30, 4, 4, 5);
    grant_q.push_back(3'b010);
    pix_q.push_back({8'd30, 7'd30, 3'd5});
    pix_q.push_back({8'd31, 7'd30, 3'd5});
    req[1] = 1'b1;
    wait_grant(m);
    chk("t5_grant_lat", m, 1);
    req[1] = 1'b0;
    tick();
    tick();
    tick();
    chk("t5_third_pixel_plot", plot, 1);
    reset = 1'b1;
    #1;
    check_all_zero("t5_async");
    @(negedge clk);
    tick();
    reset = 1'b0;
    set_rect(0, 1, 2, 1, 1, 7);
    set_rect(2, 3, 4, 1, 1, 2);
    grant_q.push_back(3'b001);
    grant_q.push_back(3'b100);
    pix_q.push_back({8'd1, 7'd2, 3'd7});
    pix_q.push_back({8'd3, 7'd4, 3'd2});
    done_q.push_back({1'b1, 3'b001});
    done_q.push_back({1'b1, 3'b100});
    req = 3'b101;
    wait_grant(m);
    chk("t5_first_grant", grant, 3'b001);
    req[0] = 1'b0;
    wait_idle("t5_occ_a", 2);
    wait_grant(m);
    chk("t5_second_grant", grant, 3'b100);
    req[2] = 1'b0;
    wait_idle("t5_occ_b", 2);
    tick();

    // 6: inputs changed mid-draw are ignored
    set_rect(0, 40, 50, 3, 1, 6);
    grant_q.push_back(3'b001);
    pix_q.push_back({8'd40, 7'd50, 3'd6});
    pix_q.push_back({8'd41, 7'd50, 3'd6});
    pix_q.push_back({8'd42, 7'd50, 3'd6});
    done_q.push_back({1'b1, 3'b001});
    req[0] = 1'b1;
    wait_grant(m);
    chk("t6_grant_lat", m, 1);
    rect_x[7:0]     = 8'd100;
    rect_color[2:0] = 3'd1;
    req[0]          = 1'b0;
    wait_idle("t6_occupancy", 4);

    tick();
    tick();
    tick();
    chk("left_pixels", pix_q.size(), 0);
    chk("left_grants", grant_q.size(), 0);
    chk("left_dones", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_plot_scheduler.md
Name: rect_plot_scheduler

Overview:
Shares the single VGA adapter plot port among NREQ rectangle-drawing requesters, such as the tile drawer, the lane/background eraser and the score painter.
A round-robin arbiter grants one requester at a time and latches its rectangle. A raster sequencer then emits one pixel per clock on VGA_X/VGA_Y/VGA_COLOR/plot, clipping to the 160x120 screen.
The block sits between the game logic and the vga_adapter inside display.

Parameters:
NREQ, 3, number of requesters (2..8)
SCR_W, 160, screen width in pixels
SCR_H, 120, screen height in pixels

Ports:
CLOCK_50  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester draw request, level
rect_x  in  NREQ*8  packed left x; requester i uses bits [8i+7:8i]
rect_y  in  NREQ*7  packed top y
rect_w  in  NREQ*8  packed width in pixels (0 = empty)
rect_h  in  NREQ*7  packed height in pixels (0 = empty)
rect_color  in  NREQ*3  packed fill colour
grant  out  NREQ  one-hot; high while the requester's rectangle is being drawn
done  out  NREQ  one-cycle completion pulse for the granted requester
busy  out  1  high whenever state is not IDLE
VGA_X  out  8  pixel x to the adapter
VGA_Y  out  7  pixel y to the adapter
VGA_COLOR  out  3  pixel colour to the adapter
plot  out  1  pixel write enable to the adapter

Behaviour:
- All outputs are registered.
- Reset (async, immediate): state=IDLE; grant, done, busy, VGA_X, VGA_Y, VGA_COLOR, plot = 0; round-robin pointer last=NREQ-1, so requester 0 is searched first.
- Reset mid-draw aborts the rectangle. No done pulse is issued.

FSM states: IDLE, DRAW, DONE.

IDLE
- On an edge with any req bit high: choose the first set req searching from last+1 upward, wrapping modulo NREQ.
- That requester's rect_x/y/w/h/color are latched; grant[i]=1, busy=1, last=i, cx=cy=0.
- If w=0 or h=0, next state is DONE; otherwise next state is DRAW.

DRAW (one pixel per edge)
- Load VGA_X=x0+cx, VGA_Y=y0+cy and VGA_COLOR=color, all truncated to port width.
- plot=1 only if (x0+cx)<SCR_W and (y0+cy)<SCR_H. Compute x with 9 bits and y with 8 bits, so there is no wrap.
- Advance raster: cx increments; at cx=w-1 it returns to 0 and cy increments.
- On the edge loading pixel (w-1,h-1): next state is DONE and done[i]=1 is set. done is therefore high in the same cycle the last pixel is on the outputs.

DONE (one cycle)
- Next edge: plot=0, done=0, grant=0, busy=0, state=IDLE.
- The earliest next grant is the following edge.

Timing
- req sampled at edge E0; first pixel output after E1; w*h consecutive pixel cycles.
- Total occupancy is w*h+1 cycles from grant to IDLE.
- Empty rectangle: done is high in the cycle after E0 with no plot.

Input rules
- req and rect_* of every requester are ignored outside the IDLE sampling edge.
- Changing the granted requester's inputs mid-draw has no effect.
- A requester still holding req when it sees done is re-arbitrated behind the others.
- Dropping req mid-draw does not abort the draw.
- Simultaneous requests: only the round-robin winner is granted; the others wait, with no starvation, for at most NREQ-1 rectangles.

Test Plan:
1. Single draw:
   - Stimulus: req[0]=1, rect (x=10, y=20, w=2, h=2, colour 3'b100).
   - Response: plot high 4 consecutive cycles starting 2 cycles after req is sampled, emitting (10,20), (11,20), (10,21), (11,21), colour 4.
   - done[0] pulses with the 4th pixel; grant[0] and busy drop one cycle later.
2. Clipping:
   - Stimulus: req[1] with x=158, y=119, w=4, h=2.
   - Response: 8 DRAW cycles; plot=1 only for (158,119) and (159,119); done[1] after the 8th cycle.
3. Empty rectangle:
   - Stimulus: req[2] with w=0, h=5.
   - Response: grant[2] and done[2] both high for exactly one cycle, the cycle after req is sampled; plot never asserted.
4. Round-robin:
   - Stimulus: all three req held high, each with a 1x1 rect.
   - Response: grant sequence 001, 010, 100, 001, ...; each grant lasts 2 cycles, with 1 IDLE cycle between grants.
5. Reset mid-draw:
   - Stimulus: during the 3rd pixel of a 4x4 draw for requester 1, pulse reset; then raise req[2] and req[0] together.
   - Response: all outputs 0 in the same cycle as reset with no done pulse; after release, requester 0 is granted first, then requester 2.
6. Input stability:
   - Stimulus: during requester 0's 3x1 draw, change rect_x[0] and rect_color[0] and drop req[0].
   - Response: all 3 pixels use the values latched at grant; done[0] is still pulsed.
